// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types for the dmem port arbiter: FSM states, requester IDs, default geometry
// and the round-robin winner selection.
package dmem_port_arbiter_pkg;

    localparam logic [31:0] DMEM_BASE_DEFAULT = 32'h1001_0000;
    localparam int          ADDR_W_DEFAULT    = 11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_DBG = 1'b1
    } req_id_e;

    // On a tie the requester that was not served last wins.
    function automatic req_id_e pick_winner(input logic    cpu_req,
                                            input logic    dbg_req,
                                            input req_id_e last_grant);
        if (cpu_req && dbg_req) begin
            return (last_grant == REQ_CPU) ? REQ_DBG : REQ_CPU;
        end
        if (cpu_req) begin
            return REQ_CPU;
        end
        return REQ_DBG;
    endfunction

endpackage

// File: rtl/dmem_addr_rebase.sv
// Converts a CPU-view byte address into a dmem word index and flags whether it
// lands inside the dmem window.
module dmem_addr_rebase
    import dmem_port_arbiter_pkg::*;
#(
    parameter logic [31:0] DMEM_BASE = DMEM_BASE_DEFAULT,
    parameter int          ADDR_W    = ADDR_W_DEFAULT
) (
    input  logic [31:0]       addr_i,
    output logic [ADDR_W-1:0] idx_o,
    output logic              in_range_o
);

    // Window size in bytes; one extra bit so ADDR_W up to 30 still compares correctly.
    localparam logic [32:0] SPAN_BYTES = 33'd4 << ADDR_W;

    logic [31:0] off;

    // Subtraction wraps, so addresses below the base become huge offsets and fail the check.
    assign off        = addr_i - DMEM_BASE;
    assign in_range_o = ({1'b0, off} < SPAN_BYTES);
    assign idx_o      = off[ADDR_W+1:2];

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the single-port dmem between the CPU data port and the debug/loader port,
// one 3-cycle IDLE/ACCESS/RESP transaction at a time with round-robin arbitration.
module dmem_port_arbiter
    import dmem_port_arbiter_pkg::*;
#(
    parameter logic [31:0] DMEM_BASE = DMEM_BASE_DEFAULT,
    parameter int          ADDR_W    = ADDR_W_DEFAULT
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [31:0]       cpu_addr_i,
    input  logic [31:0]       cpu_wdata_i,
    output logic [31:0]       cpu_rdata_o,
    output logic              cpu_ack_o,
    output logic              cpu_stall_o,
    input  logic              dbg_req_i,
    input  logic              dbg_we_i,
    input  logic [31:0]       dbg_addr_i,
    input  logic [31:0]       dbg_wdata_i,
    output logic [31:0]       dbg_rdata_o,
    output logic              dbg_ack_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    output logic              mem_we_o,
    input  logic [31:0]       mem_rdata_i,
    output logic              addr_err_o
);

    state_e            state_q, state_d;
    req_id_e           last_grant_q, last_grant_d;
    req_id_e           owner_q, owner_d;
    logic              we_q, we_d;
    logic              in_range_q, in_range_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              addr_err_q, addr_err_d;

    req_id_e           winner;
    logic [31:0]       sel_addr;
    logic [ADDR_W-1:0] sel_idx;
    logic              sel_in_range;
    logic              resp;

    assign winner   = pick_winner(cpu_req_i, dbg_req_i, last_grant_q);
    assign sel_addr = (winner == REQ_CPU) ? cpu_addr_i : dbg_addr_i;

    dmem_addr_rebase #(
        .DMEM_BASE (DMEM_BASE),
        .ADDR_W    (ADDR_W)
    ) u_rebase (
        .addr_i     (sel_addr),
        .idx_o      (sel_idx),
        .in_range_o (sel_in_range)
    );

    // NOTE: every *_d gets its hold value first, so no path through this block can infer a latch.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        we_d         = we_q;
        in_range_d   = in_range_q;
        idx_d        = idx_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        addr_err_d   = addr_err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cpu_req_i || dbg_req_i) begin
                    owner_d    = winner;
                    we_d       = (winner == REQ_CPU) ? cpu_we_i : dbg_we_i;
                    wdata_d    = (winner == REQ_CPU) ? cpu_wdata_i : dbg_wdata_i;
                    idx_d      = sel_idx;
                    in_range_d = sel_in_range;
                    state_d    = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                rdata_d    = in_range_q ? mem_rdata_i : 32'h0;
                addr_err_d = addr_err_q | ~in_range_q;
                state_d    = ST_RESP;
            end
            ST_RESP: begin
                last_grant_d = owner_q;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            last_grant_q <= REQ_DBG;
            owner_q      <= REQ_CPU;
            we_q         <= 1'b0;
            in_range_q   <= 1'b0;
            idx_q        <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            addr_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            we_q         <= we_d;
            in_range_q   <= in_range_d;
            idx_q        <= idx_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            addr_err_q   <= addr_err_d;
        end
    end

    // Decoded from the state register, so an asynchronous reset kills a pending write at once.
    assign mem_we_o    = (state_q == ST_ACCESS) && we_q && in_range_q;
    assign mem_addr_o  = idx_q;
    assign mem_wdata_o = wdata_q;

    assign resp        = (state_q == ST_RESP);
    assign cpu_ack_o   = resp && (owner_q == REQ_CPU);
    assign dbg_ack_o   = resp && (owner_q == REQ_DBG);
    assign cpu_rdata_o = cpu_ack_o ? rdata_q : 32'h0;
    assign dbg_rdata_o = dbg_ack_o ? rdata_q : 32'h0;
    assign cpu_stall_o = cpu_req_i && !cpu_ack_o;
    assign addr_err_o  = addr_err_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: a local dmem model plus per-requester
// scoreboards of expected read data, with timing checked inline by each scenario task.
module tb_dmem_port_arbiter;

    localparam int ADDR_W = 11;

    typedef struct packed {
        logic        chk;
        logic [31:0] data;
    } exp_t;

    logic              clk;
    logic              rst;
    logic              cpu_req, cpu_we;
    logic [31:0]       cpu_addr, cpu_wdata, cpu_rdata;
    logic              cpu_ack, cpu_stall;
    logic              dbg_req, dbg_we;
    logic [31:0]       dbg_addr, dbg_wdata, dbg_rdata;
    logic              dbg_ack;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata, mem_rdata;
    logic              mem_we;
    logic              addr_err;

    logic [31:0] dmem [0:(1<<ADDR_W)-1];

    exp_t cpu_exp_q[$];
    exp_t dbg_exp_q[$];
    exp_t cpu_e, dbg_e;

    int n_checks = 0;
    int n_fail   = 0;

    dmem_port_arbiter #(
        .DMEM_BASE (32'h1001_0000),
        .ADDR_W    (ADDR_W)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .cpu_req_i   (cpu_req),
        .cpu_we_i    (cpu_we),
        .cpu_addr_i  (cpu_addr),
        .cpu_wdata_i (cpu_wdata),
        .cpu_rdata_o (cpu_rdata),
        .cpu_ack_o   (cpu_ack),
        .cpu_stall_o (cpu_stall),
        .dbg_req_i   (dbg_req),
        .dbg_we_i    (dbg_we),
        .dbg_addr_i  (dbg_addr),
        .dbg_wdata_i (dbg_wdata),
        .dbg_rdata_o (dbg_rdata),
        .dbg_ack_o   (dbg_ack),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_we_o    (mem_we),
        .mem_rdata_i (mem_rdata),
        .addr_err_o  (addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port dmem model: combinational read, write on the rising edge.
    assign mem_rdata = dmem[mem_addr];
    always @(posedge clk) begin
        if (mem_we) dmem[mem_addr] <= mem_wdata;
    end

    // Scoreboard side: every ack must match the oldest expectation of that requester.
    always @(negedge clk) begin
        if (!rst) begin
            if (cpu_ack) begin
                n_checks++;
                if (cpu_exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL cpu_unexpected_ack: ack seen with nothing outstanding at %0t", $time);
                end else begin
                    cpu_e = cpu_exp_q.pop_front();
                    if (cpu_e.chk && (cpu_rdata !== cpu_e.data)) begin
                        n_fail++;
                        $display("FAIL cpu_rdata: got %08h expected %08h", cpu_rdata, cpu_e.data);
                    end
                end
                n_checks++;
                if (dbg_ack !== 1'b0 || dbg_rdata !== 32'h0) begin
                    n_fail++;
                    $display("FAIL dbg_idle_during_cpu_ack: ack %b rdata %08h expected 0/0", dbg_ack, dbg_rdata);
                end
            end
            if (dbg_ack) begin
                n_checks++;
                if (dbg_exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL dbg_unexpected_ack: ack seen with nothing outstanding at %0t", $time);
                end else begin
                    dbg_e = dbg_exp_q.pop_front();
                    if (dbg_e.chk && (dbg_rdata !== dbg_e.data)) begin
                        n_fail++;
                        $display("FAIL dbg_rdata: got %08h expected %08h", dbg_rdata, dbg_e.data);
                    end
                end
                n_checks++;
                if (cpu_rdata !== 32'h0) begin
                    n_fail++;
                    $display("FAIL cpu_rdata_nonowner: got %08h expected 00000000", cpu_rdata);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 32'h0; dbg_wdata = 32'h0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        cpu_exp_q.delete();
        dbg_exp_q.delete();
        rst = 1'b0;
    endtask

    // Uncontested access started just after a falling edge; returns once the FSM is back in IDLE.
    task automatic do_access(input logic is_dbg, input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [31:0] exp_rdata,
                             input logic exp_mem_we, input logic [ADDR_W-1:0] exp_idx,
                             input string tag);
        int cyc;
        bit done;
        if (is_dbg) begin
            dbg_we = we; dbg_addr = addr; dbg_wdata = wdata; dbg_req = 1'b1;
            dbg_exp_q.push_back('{chk: !we, data: exp_rdata});
        end else begin
            cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_req = 1'b1;
            cpu_exp_q.push_back('{chk: !we, data: exp_rdata});
            #1;
            n_checks++;
            if (cpu_stall !== 1'b1) begin
                n_fail++;
                $display("FAIL %s stall_c1: got %b expected 1", tag, cpu_stall);
            end
        end
        cyc  = 1;
        done = 1'b0;
        while (!done && cyc < 8) begin
            @(negedge clk);
            cyc++;
            if (cyc == 2) begin
                n_checks++;
                if (mem_we !== exp_mem_we) begin
                    n_fail++;
                    $display("FAIL %s access_we: got %b expected %b", tag, mem_we, exp_mem_we);
                end
                if (exp_mem_we) begin
                    n_checks++;
                    if (mem_addr !== exp_idx || mem_wdata !== wdata) begin
                        n_fail++;
                        $display("FAIL %s access_bus: got addr %0d data %08h expected addr %0d data %08h",
                                 tag, mem_addr, mem_wdata, exp_idx, wdata);
                    end
                end
                if (!is_dbg) begin
                    n_checks++;
                    if (cpu_stall !== 1'b1) begin
                        n_fail++;
                        $display("FAIL %s stall_c2: got %b expected 1", tag, cpu_stall);
                    end
                end
            end
            if (is_dbg ? dbg_ack : cpu_ack) begin
                done = 1'b1;
                n_checks++;
                if (cyc != 3 || mem_we !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s ack_timing: ack in cycle %0d mem_we %b expected cycle 3 mem_we 0",
                             tag, cyc, mem_we);
                end
                if (!is_dbg) begin
                    n_checks++;
                    if (cpu_stall !== 1'b0) begin
                        n_fail++;
                        $display("FAIL %s stall_ack: got %b expected 0", tag, cpu_stall);
                    end
                end
                if (is_dbg) dbg_req = 1'b0;
                else        cpu_req = 1'b0;
            end
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s ack_timeout: no ack within %0d cycles", tag, cyc);
            cpu_req = 1'b0;
            dbg_req = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        #1;
        n_checks++;
        if ({cpu_ack, dbg_ack, cpu_stall, mem_we, addr_err, cpu_rdata, dbg_rdata, mem_addr, mem_wdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: ack %b/%b stall %b we %b err %b rdata %08h/%08h addr %0d wdata %08h expected all 0",
                     cpu_ack, dbg_ack, cpu_stall, mem_we, addr_err, cpu_rdata, dbg_rdata, mem_addr, mem_wdata);
        end
        apply_reset();
        repeat (2) @(negedge clk);
        n_checks++;
        if ({cpu_ack, dbg_ack, mem_we, addr_err} !== 4'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: ack %b/%b we %b err %b expected 0", cpu_ack, dbg_ack, mem_we, addr_err);
        end
    endtask

    task automatic test_cpu_write_read();
        do_access(1'b0, 1'b1, 32'h1001_0008, 32'hDEAD_BEEF, 32'h0, 1'b1, 11'd2, "cpu_wr");
        n_checks++;
        if (dmem[2] !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL cpu_wr_commit: dmem[2] %08h expected deadbeef", dmem[2]);
        end
        do_access(1'b0, 1'b0, 32'h1001_0008, 32'h0, 32'hDEAD_BEEF, 1'b0, 11'd2, "cpu_rd");
    endtask

    task automatic test_tie_arbitration();
        int cpu_cyc, dbg_cyc, n_acks;
        int ack_cyc[4];
        logic [3:0] ack_dbg;
        apply_reset();
        cpu_we = 1'b0; cpu_addr = 32'h1001_0008;
        dbg_we = 1'b1; dbg_addr = 32'h1001_000C; dbg_wdata = 32'h1234_5678;
        cpu_exp_q.push_back('{chk: 1'b1, data: 32'hDEAD_BEEF});
        dbg_exp_q.push_back('{chk: 1'b0, data: 32'h0});
        cpu_req = 1'b1; dbg_req = 1'b1;
        cpu_cyc = 0; dbg_cyc = 0;
        for (int cyc = 2; cyc <= 10; cyc++) begin
            @(negedge clk);
            if (cpu_ack) begin cpu_cyc = cyc; cpu_req = 1'b0; end
            if (dbg_ack) begin dbg_cyc = cyc; dbg_req = 1'b0; end
        end
        cpu_req = 1'b0; dbg_req = 1'b0;
        n_checks++;
        if (cpu_cyc != 3 || dbg_cyc != 6) begin
            n_fail++;
            $display("FAIL tie_first_order: cpu ack cycle %0d dbg ack cycle %0d expected 3 and 6", cpu_cyc, dbg_cyc);
        end
        n_checks++;
        if (dmem[3] !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL tie_dbg_write: dmem[3] %08h expected 12345678", dmem[3]);
        end
        // Both held continuously: grants must alternate starting with the CPU.
        dbg_we = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cpu_exp_q.push_back('{chk: 1'b1, data: 32'hDEAD_BEEF});
            dbg_exp_q.push_back('{chk: 1'b1, data: 32'h1234_5678});
        end
        cpu_req = 1'b1; dbg_req = 1'b1;
        n_acks = 0;
        ack_dbg = 4'b0;
        for (int cyc = 2; cyc <= 13 && n_acks < 4; cyc++) begin
            @(negedge clk);
            if (cpu_ack || dbg_ack) begin
                ack_cyc[n_acks] = cyc;
                ack_dbg[n_acks] = dbg_ack;
                n_acks++;
            end
        end
        cpu_req = 1'b0; dbg_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (n_acks != 4 || ack_dbg !== 4'b1010) begin
            n_fail++;
            $display("FAIL tie_alternate: %0d acks owner bits %b expected 4 acks owner bits 1010", n_acks, ack_dbg);
        end else begin
            n_checks++;
            if (ack_cyc[0] != 3 || ack_cyc[1] != 6 || ack_cyc[2] != 9 || ack_cyc[3] != 12) begin
                n_fail++;
                $display("FAIL tie_spacing: ack cycles %0d %0d %0d %0d expected 3 6 9 12",
                         ack_cyc[0], ack_cyc[1], ack_cyc[2], ack_cyc[3]);
            end
        end
    endtask

    task automatic test_out_of_range();
        n_checks++;
        if (addr_err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_clear: got %b expected 0", addr_err);
        end
        do_access(1'b0, 1'b1, 32'h1001_0000, 32'h1111_0000, 32'h0, 1'b1, 11'd0, "wr_word0");
        do_access(1'b0, 1'b0, 32'h1000_0000, 32'h0, 32'h0, 1'b0, 11'd0, "rd_below");
        n_checks++;
        if (addr_err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_below: got %b expected 1", addr_err);
        end
        do_access(1'b0, 1'b0, 32'h1001_2000, 32'h0, 32'h0, 1'b0, 11'd0, "rd_above");
        do_access(1'b0, 1'b1, 32'h1001_2000, 32'h0000_0BAD, 32'h0, 1'b0, 11'd0, "wr_above");
        do_access(1'b0, 1'b0, 32'h1001_0000, 32'h0, 32'h1111_0000, 1'b0, 11'd0, "rd_word0");
        do_access(1'b0, 1'b1, 32'h1001_1FFC, 32'h0BAD_F00D, 32'h0, 1'b1, 11'd2047, "wr_top");
        do_access(1'b0, 1'b0, 32'h1001_1FFC, 32'h0, 32'h0BAD_F00D, 1'b0, 11'd2047, "rd_top");
        n_checks++;
        if (addr_err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_sticky: got %b expected 1", addr_err);
        end
    endtask

    task automatic test_reset_mid_access();
        int seen_ack;
        do_access(1'b1, 1'b1, 32'h1001_0010, 32'hCAFE_F00D, 32'h0, 1'b1, 11'd4, "dbg_wr_pre");
        dbg_we = 1'b1; dbg_addr = 32'h1001_0010; dbg_wdata = 32'h0000_0005; dbg_req = 1'b1;
        @(negedge clk);
        n_checks++;
        if (mem_we !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_access_we: got %b expected 1", mem_we);
        end
        #1;
        rst = 1'b1;
        dbg_req = 1'b0;
        #1;
        n_checks++;
        if ({cpu_ack, dbg_ack, mem_we, addr_err, cpu_rdata, dbg_rdata, mem_addr, mem_wdata} !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: ack %b/%b we %b err %b rdata %08h/%08h addr %0d wdata %08h expected all 0",
                     cpu_ack, dbg_ack, mem_we, addr_err, cpu_rdata, dbg_rdata, mem_addr, mem_wdata);
        end
        @(negedge clk);
        rst = 1'b0;
        seen_ack = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (dbg_ack || cpu_ack) seen_ack++;
        end
        n_checks++;
        if (seen_ack != 0 || dmem[4] !== 32'hCAFE_F00D) begin
            n_fail++;
            $display("FAIL mid_reset_abort: %0d acks dmem[4] %08h expected 0 acks and cafef00d", seen_ack, dmem[4]);
        end
    endtask

    task automatic test_dbg_stream();
        int dbg_acks, cpu_acks;
        int last_cyc, bad_gap;
        for (int i = 0; i < 4; i++) dbg_exp_q.push_back('{chk: 1'b1, data: 32'hCAFE_F00D});
        dbg_we = 1'b0; dbg_addr = 32'h1001_0010; dbg_req = 1'b1;
        dbg_acks = 0; cpu_acks = 0; last_cyc = 0; bad_gap = 0;
        for (int cyc = 2; cyc <= 14 && dbg_acks < 4; cyc++) begin
            @(negedge clk);
            if (cpu_ack) cpu_acks++;
            if (dbg_ack) begin
                if (cyc - last_cyc != 3) bad_gap++;
                last_cyc = cyc;
                dbg_acks++;
            end
        end
        dbg_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (dbg_acks != 4 || bad_gap != 0 || cpu_acks != 0) begin
            n_fail++;
            $display("FAIL dbg_stream: %0d dbg acks %0d bad gaps %0d cpu acks expected 4/0/0", dbg_acks, bad_gap, cpu_acks);
        end
    endtask

    task automatic test_cpu_pulse_dropped();
        int cpu_acks, dbg_acks, late_we;
        dbg_exp_q.push_back('{chk: 1'b1, data: 32'hCAFE_F00D});
        dbg_we = 1'b0; dbg_addr = 32'h1001_0010; dbg_req = 1'b1;
        cpu_we = 1'b1; cpu_addr = 32'h1001_0010; cpu_wdata = 32'hFFFF_FFFF;
        cpu_acks = 0; dbg_acks = 0; late_we = 0;
        for (int cyc = 2; cyc <= 10; cyc++) begin
            @(negedge clk);
            if (cpu_ack) cpu_acks++;
            if (dbg_ack) dbg_acks++;
            if (cyc >= 3 && mem_we) late_we++;
            if (cyc == 2) cpu_req = 1'b1;
            if (cyc == 3) begin cpu_req = 1'b0; dbg_req = 1'b0; end
        end
        n_checks++;
        if (cpu_acks != 0 || dbg_acks != 1 || late_we != 0 || dmem[4] !== 32'hCAFE_F00D) begin
            n_fail++;
            $display("FAIL cpu_pulse: cpu acks %0d dbg acks %0d late we %0d dmem[4] %08h expected 0/1/0/cafef00d",
                     cpu_acks, dbg_acks, late_we, dmem[4]);
        end
    endtask

    initial begin
        test_reset();
        test_cpu_write_read();
        test_tie_arbitration();
        test_out_of_range();
        test_reset_mid_access();
        test_dbg_stream();
        test_cpu_pulse_dropped();
        repeat (2) @(negedge clk);
        n_checks++;
        if (cpu_exp_q.size() != 0 || dbg_exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d cpu and %0d dbg responses outstanding expected 0",
                     cpu_exp_q.size(), dbg_exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
